// File: rtl/sfp_pkg.sv
// Shared definitions for the special-function processor: activation codes,
// per-lane mode priority and the per-row mode word that travels with each row.
package sfp_pkg;

    localparam int unsigned ACT_W     = 2;
    localparam int unsigned ROW_CNT_W = 16;

    typedef enum logic [ACT_W-1:0] {
        ACT_NONE  = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_LEAKY = 2'b10
    } act_t;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'd0,
        MODE_ACCUM = 2'd1,
        MODE_PASS  = 2'd2
    } lane_mode_t;

    typedef struct packed {
        logic             passthrough;
        logic             accum;
        logic [ACT_W-1:0] act;
        logic             sat_en;
    } mode_t;

    // Passthrough beats accumulate, accumulate beats plain load.
    function automatic lane_mode_t decode_mode(input mode_t m);
        if (m.passthrough) return MODE_PASS;
        if (m.accum)       return MODE_ACCUM;
        return MODE_LOAD;
    endfunction

endpackage

// File: rtl/sfp_array_if.sv
// Row handshake, operand/result lanes and status for the SFP array.
interface sfp_array_if
    import sfp_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [col*psum_bw-1:0]   psum_in;
    logic [col*psum_bw-1:0]   ofifo_in;
    logic                     passthrough;
    logic                     accum;
    logic [ACT_W-1:0]         act;
    logic                     sat_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [col*psum_bw-1:0]   sfp_out;
    logic [col-1:0]           ovf_flags;
    logic                     ovf_clr;
    logic [ROW_CNT_W-1:0]     row_count;

    modport master (
        output in_valid, psum_in, ofifo_in, passthrough, accum, act, sat_en,
               out_ready, ovf_clr,
        input  in_ready, out_valid, sfp_out, ovf_flags, row_count
    );

    modport slave (
        input  in_valid, psum_in, ofifo_in, passthrough, accum, act, sat_en,
               out_ready, ovf_clr,
        output in_ready, out_valid, sfp_out, ovf_flags, row_count
    );
endinterface

// File: rtl/sfp_lane.sv
// One SFP lane: widened add feeding S1, and saturate/wrap plus activation
// feeding S2. Purely combinational; the pipeline registers live in sfp_array.
module sfp_lane
    import sfp_pkg::*;
#(
    parameter int unsigned psum_bw    = 16,
    parameter int unsigned leak_shift = 6
) (
    input  logic signed [psum_bw-1:0] psum,
    input  logic signed [psum_bw-1:0] ofifo,
    output logic signed [psum_bw:0]   sum_c,
    input  logic signed [psum_bw:0]   s1_sum,
    input  logic signed [psum_bw-1:0] s1_psum,
    input  logic signed [psum_bw-1:0] s1_ofifo,
    input  mode_t                     s1_mode,
    output logic signed [psum_bw-1:0] result_c,
    output logic                      ovf_c
);
    localparam logic [psum_bw-1:0] MAX_VAL = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] MIN_VAL = {1'b1, {(psum_bw-1){1'b0}}};

    lane_mode_t               lane_mode;
    logic signed [psum_bw-1:0] clamped;

    // Sign-extended add cannot itself overflow.
    always_comb begin
        sum_c = {psum[psum_bw-1], psum} + {ofifo[psum_bw-1], ofifo};
    end

    always_comb begin
        lane_mode = decode_mode(s1_mode);
        ovf_c     = 1'b0;
        clamped   = s1_psum;
        result_c  = s1_ofifo;
        if (lane_mode == MODE_ACCUM) begin
            // Out of range exactly when the two top bits of the wide sum disagree.
            ovf_c = s1_sum[psum_bw] != s1_sum[psum_bw-1];
            if (ovf_c && s1_mode.sat_en) begin
                clamped = s1_sum[psum_bw] ? MIN_VAL : MAX_VAL;
            end else begin
                clamped = s1_sum[psum_bw-1:0];
            end
        end
        if (lane_mode != MODE_PASS) begin
            result_c = clamped;
            if (clamped[psum_bw-1]) begin
                case (s1_mode.act)
                    ACT_RELU:  result_c = '0;
                    ACT_LEAKY: result_c = clamped >>> leak_shift;
                    default:   result_c = clamped;
                endcase
            end
        end
    end

endmodule

// File: rtl/sfp_array.sv
// Multi-lane two-stage valid/ready SFP: S1 holds sums/operands/mode, S2 holds
// the finished row. Also keeps sticky per-lane overflow flags and a row counter.
module sfp_array
    import sfp_pkg::*;
#(
    parameter int unsigned col        = 8,
    parameter int unsigned psum_bw    = 16,
    parameter int unsigned leak_shift = 6
) (
    input  logic        clk,
    input  logic        reset,
    sfp_array_if.slave  bus
);
    localparam int unsigned ROW_W = col * psum_bw;
    localparam int unsigned SUM_W = psum_bw + 1;

    logic                   en;
    mode_t                  in_mode;
    logic                   s1_valid;
    mode_t                  s1_mode;
    logic [ROW_W-1:0]       s1_psum;
    logic [ROW_W-1:0]       s1_ofifo;
    logic [col*SUM_W-1:0]   s1_sum;
    logic [col*SUM_W-1:0]   sum_c;
    logic [ROW_W-1:0]       result_c;
    logic [col-1:0]         ovf_c;

    // Both stages move together; a full S2 that is not being taken stalls everything.
    assign en           = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;

    assign in_mode = '{passthrough: bus.passthrough, accum: bus.accum,
                       act: bus.act, sat_en: bus.sat_en};

    for (genvar i = 0; i < col; i++) begin : g_lane
        sfp_lane #(
            .psum_bw    (psum_bw),
            .leak_shift (leak_shift)
        ) u_lane (
            .psum     (bus.psum_in[i*psum_bw +: psum_bw]),
            .ofifo    (bus.ofifo_in[i*psum_bw +: psum_bw]),
            .sum_c    (sum_c[i*SUM_W +: SUM_W]),
            .s1_sum   (s1_sum[i*SUM_W +: SUM_W]),
            .s1_psum  (s1_psum[i*psum_bw +: psum_bw]),
            .s1_ofifo (s1_ofifo[i*psum_bw +: psum_bw]),
            .s1_mode  (s1_mode),
            .result_c (result_c[i*psum_bw +: psum_bw]),
            .ovf_c    (ovf_c[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_mode       <= '0;
            s1_psum       <= '0;
            s1_ofifo      <= '0;
            s1_sum        <= '0;
            bus.out_valid <= 1'b0;
            bus.sfp_out   <= '0;
            bus.ovf_flags <= '0;
            bus.row_count <= '0;
        end else begin
            if (en) begin
                s1_valid      <= bus.in_valid;
                bus.out_valid <= s1_valid;
                if (bus.in_valid) begin
                    s1_mode  <= in_mode;
                    s1_psum  <= bus.psum_in;
                    s1_ofifo <= bus.ofifo_in;
                    s1_sum   <= sum_c;
                end
                if (s1_valid) begin
                    bus.sfp_out <= result_c;
                end
            end
            // A lane setting on the same cycle as a clear stays set.
            if (bus.ovf_clr) begin
                bus.ovf_flags <= (en && s1_valid) ? ovf_c : '0;
            end else if (en && s1_valid) begin
                bus.ovf_flags <= bus.ovf_flags | ovf_c;
            end
            if (bus.out_valid && bus.out_ready) begin
                bus.row_count <= bus.row_count + ROW_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sfp_array.sv
// Bench for sfp_array: directed rows plus randomized traffic and backpressure,
// scored against an integer-arithmetic model of the lane rules.
module tb_sfp_array;
    localparam int COL  = 8;
    localparam int PW   = 16;
    localparam int LS   = 6;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;

    typedef struct {
        int       p [COL];
        int       o [COL];
        bit       pt;
        bit       ac;
        bit       sat;
        bit [1:0] act;
    } row_t;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rdy_mode = 0;
    int   n_rows_model = 0;
    logic [7:0] flags_model = '0;
    exp_t exp_q[$];

    sfp_array_if #(.col(COL), .psum_bw(PW)) bus ();

    sfp_array #(.col(COL), .psum_bw(PW), .leak_shift(LS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: integer sum, range test, clamp or +-2^16 wrap, then floor-divide for leaky.
    function automatic exp_t model(input row_t r);
        exp_t e;
        int   v;
        e.ovf = '0;
        e.data = '0;
        for (int i = 0; i < COL; i++) begin
            if (r.pt) begin
                v = r.o[i];
            end else begin
                v = r.ac ? r.p[i] + r.o[i] : r.p[i];
                if (r.ac && (v > MAXV || v < MINV)) begin
                    e.ovf[i] = 1'b1;
                    if (r.sat) v = (v > MAXV) ? MAXV : MINV;
                    else       v = (v > MAXV) ? v - 65536 : v + 65536;
                end
                if (v < 0) begin
                    if (r.act == 2'b01)      v = 0;
                    else if (r.act == 2'b10) v = -((-v + (1 << LS) - 1) / (1 << LS));
                end
            end
            e.data[i*PW +: PW] = PW'(v);
        end
        return e;
    endfunction

    function automatic row_t mk(input int p0, input int o0, input bit pt, input bit ac,
                                input bit sat, input bit [1:0] act);
        row_t r;
        for (int i = 0; i < COL; i++) begin
            r.p[i] = 0;
            r.o[i] = 0;
        end
        r.p[0] = p0;
        r.o[0] = o0;
        r.pt = pt; r.ac = ac; r.sat = sat; r.act = act;
        return r;
    endfunction

    function automatic int rand_val();
        if ($urandom_range(3) == 0)
            return ($urandom_range(1) == 1) ? MAXV - int'($urandom_range(200))
                                            : MINV + int'($urandom_range(200));
        return int'($urandom_range(65535)) - 32768;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < COL; i++) begin
            r.p[i] = rand_val();
            r.o[i] = rand_val();
        end
        r.pt  = ($urandom_range(4) == 0);
        r.ac  = ($urandom_range(1) == 1);
        r.sat = ($urandom_range(1) == 1);
        r.act = 2'($urandom_range(3));
        return r;
    endfunction

    // Present a row, hold until accepted (bounded), then drop in_valid.
    task automatic send_row(input row_t r);
        int n = 0;
        bus.in_valid    = 1'b1;
        bus.passthrough = r.pt;
        bus.accum       = r.ac;
        bus.sat_en      = r.sat;
        bus.act         = r.act;
        for (int i = 0; i < COL; i++) begin
            bus.psum_in[i*PW +: PW]  = PW'(r.p[i]);
            bus.ofifo_in[i*PW +: PW] = PW'(r.o[i]);
        end
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 1'b0, 1'b1);
        end else begin
            exp_q.push_back(model(r));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    // Single row with out_ready high: not visible after S1, visible after S2.
    task automatic run_one(input row_t r, input logic [15:0] exp0, input string tag);
        send_row(r);
        check({tag, "_s1_quiet"}, bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check(tag, bus.sfp_out[15:0], exp0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_row_count"}, bus.row_count, 128'(n_rows_model % 65536));
        check({tag, "_ovf_flags"}, bus.ovf_flags, flags_model);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Scoreboard: every delivered row must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_row", bus.sfp_out, 128'(0));
                check("unexpected_row_valid", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("row_data", bus.sfp_out, e.data);
                flags_model = flags_model | e.ovf;
                n_rows_model++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;
        exp_t e1;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.psum_in     = '0;
        bus.ofifo_in    = '0;
        bus.passthrough = 1'b0;
        bus.accum       = 1'b0;
        bus.act         = 2'b00;
        bus.sat_en      = 1'b0;
        bus.out_ready   = 1'b1;
        bus.ovf_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_sfp_out", bus.sfp_out, 128'(0));
        check_status("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Plain accumulate.
        run_one(mk(100, -30, 0, 1, 0, 2'b00), 16'd70, "accum_70");
        drain();
        check("accum_row_count_one", bus.row_count, 128'(1));
        check_status("accum");

        // Saturate vs wrap, flags sticky, then cleared.
        run_one(mk(32000, 1000, 0, 1, 1, 2'b00), 16'h7fff, "sat_max");
        run_one(mk(32000, 1000, 0, 1, 0, 2'b00), 16'h80e8, "wrap");
        drain();
        check("ovf_lane0_set", bus.ovf_flags, 8'h01);
        check_status("ovf");
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b0;
        flags_model = '0;
        check("ovf_cleared", bus.ovf_flags, 8'h00);
        run_one(mk(-30000, -5000, 0, 1, 1, 2'b00), 16'h8000, "sat_min");

        // Activations.
        run_one(mk(-600, -40, 0, 1, 0, 2'b01), 16'h0000, "relu");
        run_one(mk(-600, -40, 0, 1, 0, 2'b10), 16'hfff6, "leaky");
        run_one(mk(-600, -5, 1, 0, 0, 2'b01), 16'hfffb, "pass_bypass");
        run_one(mk(-600, -40, 0, 0, 0, 2'b11), 16'hfda8, "load_reserved_act");
        drain();
        check_status("act");

        // Mode change on consecutive rows.
        send_row(mk(100, 23, 0, 1, 0, 2'b00));
        send_row(mk(100, 23, 1, 0, 0, 2'b00));
        check("mode_a_accum", bus.sfp_out[15:0], 16'd123);
        @(posedge clk);
        #1;
        check("mode_b_pass", bus.sfp_out[15:0], 16'd23);
        drain();

        // Backpressure: two rows fill the pipe, output must freeze.
        rdy_mode = 2;
        bus.out_ready = 1'b0;
        e1 = model(mk(11, 0, 0, 1, 0, 2'b00));
        send_row(mk(11, 0, 0, 1, 0, 2'b00));
        send_row(mk(22, 0, 0, 1, 0, 2'b00));
        repeat (3) begin
            check("bp_in_ready_low", bus.in_ready, 1'b0);
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_hold_row1", bus.sfp_out, e1.data);
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        bus.out_ready = 1'b1;
        send_row(mk(33, 0, 0, 1, 0, 2'b00));
        send_row(mk(44, 0, 0, 1, 0, 2'b00));
        drain();
        check_status("bp");

        // Randomized traffic under random backpressure.
        rdy_mode = 1;
        repeat (300) begin
            r = rand_row();
            send_row(r);
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        check_status("random");

        // Reset with two rows in flight.
        send_row(mk(32000, 1000, 0, 1, 1, 2'b00));
        send_row(mk(5, 5, 0, 1, 0, 2'b00));
        reset = 1'b1;
        #1;
        exp_q.delete();
        n_rows_model = 0;
        flags_model  = '0;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check_status("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", bus.out_valid, 1'b0);
        end
        run_one(mk(1, 2, 0, 1, 0, 2'b00), 16'd3, "post_rst_row");
        drain();
        check_status("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sfp_array.md
# sfp_array

Multi-lane, pipelined special-function processor for the output path: reads one row of `col` partial sums from the PSUM SRAM and one row from the output FIFO, then applies passthrough, accumulate or plain load to each lane, followed by an optional activation (ReLU / leaky ReLU). The result row goes back to the PSUM SRAM. Added over the single-lane combinational SFP:
- parametrised lane count and width;
- optional saturating add;
- leaky-ReLU mode;
- a 2-stage valid/ready pipeline;
- sticky per-lane overflow flags and a row counter.

## Interface
Parameters:
- `col`, 8, number of lanes (one per array column)
- `psum_bw`, 16, width of each lane's psum
- `leak_shift`, 6, arithmetic right-shift applied to negative values in leaky-ReLU mode

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `in_valid`  in  1  input row present
- `in_ready`  out  1  row accepted on cycle where `in_valid & in_ready`
- `psum_in`  in  col*psum_bw  signed lanes from PSUM SRAM; lane i at `[i*psum_bw +: psum_bw]`
- `ofifo_in`  in  col*psum_bw  signed lanes from OFIFO, same packing
- `passthrough`  in  1  output = `ofifo_in` unmodified
- `accum`  in  1  output = `psum_in + ofifo_in` (else `psum_in`)
- `act`  in  2  00 none, 01 ReLU, 10 leaky ReLU, 11 reserved (treated as none)
- `sat_en`  in  1  saturate accumulate result instead of wrapping
- `out_valid`  out  1  result row valid
- `out_ready`  in  1  consumer accepts row
- `sfp_out`  out  col*psum_bw  result lanes, same packing
- `ovf_flags`  out  col  sticky per-lane accumulate-overflow flags
- `ovf_clr`  in  1  synchronous clear of `ovf_flags`
- `row_count`  out  16  number of rows delivered (`out_valid & out_ready`), wraps

## Operation
**Sampling.** `passthrough`, `accum`, `act`, `sat_en` are sampled with the row on acceptance and travel down the pipeline with it. Mode changes never affect rows already in flight.

**Per-lane mode priority:** passthrough > accum > load.
- Passthrough: result = `ofifo_in`. Activation and saturation are bypassed.
- Accum: compute the `psum_bw+1`-bit signed sum. The lane overflows when the sum lies outside [−2^(psum_bw−1), 2^(psum_bw−1)−1].
  - `sat_en=1`: clamp to max/min.
  - `sat_en=0`: keep the low `psum_bw` bits (wrap).
- Load: result = `psum_in`.

**Activation** (non-passthrough only), applied to the post-saturation/wrap value:
- ReLU: negative → 0.
- Leaky: negative → value >>> `leak_shift` (sign-preserving, rounds toward −inf).
- Non-negative values are unchanged.

**Overflow flags.** A lane's `ovf_flags` bit sets when an accum-mode row with an overflowing lane reaches stage 2 and advances. This happens regardless of `sat_en`.
- Passthrough and load rows never set flags.
- `ovf_clr` clears all bits.
- If a set and `ovf_clr` occur on the same cycle, the set wins for that lane.

## Timing
**Pipeline stages:**
- S1 registers the raw `psum_bw+1`-bit sums, operands and mode bits.
- S2 registers the saturated/activated `sfp_out` and `out_valid`.

**Latency and throughput.** Latency is 2 cycles from acceptance to `out_valid` with no stall. Throughput is 1 row/cycle.

**Stall rule.** `en = ~out_valid | out_ready`. Both stages advance only when `en`=1, and `in_ready = en` (combinational from `out_ready`). While stalled:
- S1 and S2 hold their contents;
- `sfp_out` is stable and `out_valid` stays asserted.

**Bubbles.** S1 carries a valid bit. A bubble in S1 advancing into S2 drives `out_valid`=0.

**Reset values:**
- `out_valid`=0, `sfp_out`=0, S1 valid=0;
- `ovf_flags`=0, `row_count`=0;
- `in_ready`=1 as soon as reset is asserted.

Reset asserted mid-stream discards all in-flight rows immediately; nothing is emitted after release.

**Counter.** `row_count` increments on the cycle `out_valid & out_ready`. It wraps 0xFFFF→0.

## Structure
- Shared package `sfp_pkg`: `act` encodings (`ACT_NONE`, `ACT_RELU`, `ACT_LEAKY`) and the mode-priority constants. The SRAM/FIFO wrappers use the same package.
- Sub-module `sfp_lane` (one instance per lane, `generate` loop). Two functions:
  - combinational add/overflow detect feeding S1;
  - saturate/activate logic feeding S2.
- `sfp_array` owns the pipeline registers, stall logic, flags and counter.

## Test plan
1. **Plain accum, no stall.** `accum=1, act=00`, lane0 psum=100, ofifo=−30 → `sfp_out` lane0=70 exactly 2 cycles after acceptance; `row_count`=1.
2. **Saturation vs. wrap.** Lane0 psum=32000, ofifo=1000, `accum=1`:
   - `sat_en=1` → 32767;
   - `sat_en=0` → −32536 (wrapped);
   - `ovf_flags[0]`=1 in both cases; `ovf_clr` then returns it to 0.
3. **Activations on accumulated −640 (psum=−600, ofifo=−40).**
   - `act=01` → 0;
   - `act=10` → −10;
   - `passthrough=1, act=01`, ofifo=−5 → −5.
4. **Backpressure.** Stream 4 rows with `out_ready` held low from cycle 3 → `in_ready` drops while `out_valid`=1. `sfp_out` holds the row-1 value. After release, rows emerge in order with no loss or duplication; `row_count`=4.
5. **Mode change in flight.** Row A (`accum=1`) is followed next cycle by row B (`passthrough=1`) → A is still accumulated and B is passed through.
6. **Reset mid-operation.** Assert `reset` with 2 rows in flight → `out_valid`=0, `ovf_flags`=0 and `row_count`=0 immediately (asynchronous). No output appears after release until new input is given.
